// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from the upstream FIFO and serialises them LSB first (8N1 default).
// Define UART_TX_PARITY_EN to append an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_DONE = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_nx;
    logic                  tx_nx, pop_nx, done_nx, busy_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx;
    logic [BAUD_W-1:0]     baud_cnt, baud_nx;
    logic [BIT_W-1:0]      bit_idx, bit_nx;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit, parity_nx;
`endif

    // State and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_pop   <= 1'b0;
            tx_done    <= 1'b0;
            shift      <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            fifo_pop   <= pop_nx;
            tx_done    <= done_nx;
            shift      <= shift_nx;
            baud_cnt   <= baud_nx;
            bit_idx    <= bit_nx;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_nx;
`endif
        end
    end

    // Next state plus the next value of every registered output
    always_comb begin
        state_nx  = state;
        tx_nx     = tx;
        pop_nx    = 1'b0;
        done_nx   = 1'b0;
        shift_nx  = shift;
        baud_nx   = baud_cnt;
        bit_nx    = bit_idx;
`ifdef UART_TX_PARITY_EN
        parity_nx = parity_bit;
`endif

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    state_nx = POP;
                    pop_nx   = 1'b1;
                end
            end
            POP: begin
                state_nx = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid in this cycle, one cycle after the pop edge
                shift_nx  = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_nx = ^fifo_data;
`endif
                baud_nx   = '0;
                tx_nx     = 1'b0;
                state_nx  = START;
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    tx_nx    = shift[0];
                    shift_nx = shift >> 1;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nx = '0;
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_nx    = parity_bit;
                        state_nx = PARITY;
`else
                        tx_nx    = 1'b1;
                        state_nx = STOP;
`endif
                    end else begin
                        bit_nx   = bit_idx + BIT_W'(1);
                        tx_nx    = shift[0];
                        shift_nx = shift >> 1;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nx  = '0;
                    tx_nx    = 1'b1;
                    state_nx = STOP;
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                // Raise tx_done so it lands on the final stop-bit cycle
                if (baud_cnt == BAUD_DONE) begin
                    done_nx = 1'b1;
                end
                if (baud_cnt == BAUD_LAST) begin
                    baud_nx  = '0;
                    tx_nx    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule
